// File: rtl/cook_controller.sv
// ============================================================================
//  Module      : cook_controller
//  Description : Microwave cook sequencer: keypad entry, start/stop/door
//                arbitration, 1 Hz decrement strobe, magnetron and alarm.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cook_controller #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int ALARM_CYCLES = 100_000_000
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_data,
    output logic       timer_loadn,
    output logic       timer_clearn,
    output logic       timer_enable,
    output logic       mag_on,
    output logic       alarm,
    output logic       busy
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ALARM_CYCLES) + 1;
    localparam logic [PW-1:0] c_TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] c_ALARM_LAST = AW'(ALARM_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state, w_state;
    logic [1:0]    r_digit_cnt, w_digit_cnt;
    logic [PW-1:0] r_presc, w_presc;
    logic [AW-1:0] r_alarm_cnt, w_alarm_cnt;
    logic [3:0]    r_timer_data, w_timer_data;
    logic          r_timer_loadn, w_timer_loadn;
    logic          r_timer_clearn, w_timer_clearn;
    logic          r_timer_enable, w_timer_enable;
    logic          r_mag_on, r_alarm, r_busy;
    logic          w_key_ok;

    assign w_key_ok = key_valid && (key_code <= 4'd9) && (r_digit_cnt != 2'd3);

    // Each branch raises at most one strobe, keeping load/clear/enable exclusive.
    always_comb begin
        w_state        = r_state;
        w_digit_cnt    = r_digit_cnt;
        w_presc        = r_presc;
        w_alarm_cnt    = r_alarm_cnt;
        w_timer_data   = r_timer_data;
        w_timer_loadn  = 1'b1;
        w_timer_clearn = 1'b1;
        w_timer_enable = 1'b0;
        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (stop_btn) begin
                    w_timer_clearn = 1'b0;
                    w_digit_cnt    = 2'd0;
                    w_state        = S_IDLE;
                end else if (start_btn && (r_state == S_ENTRY) && door_closed && !timer_zero) begin
                    w_presc = '0;
                    w_state = S_COOK;
                end else if (w_key_ok) begin
                    w_timer_data  = key_code;
                    w_timer_loadn = 1'b0;
                    w_digit_cnt   = r_digit_cnt + 2'd1;
                    w_state       = S_ENTRY;
                end
            end
            S_COOK: begin
                if (!door_closed || stop_btn) begin
                    w_state = S_PAUSE;
                end else if (timer_zero) begin
                    w_alarm_cnt = '0;
                    w_state     = S_DONE;
                end else begin
                    w_timer_enable = (r_presc == c_TICK_LAST);
                    w_presc        = (r_presc == c_TICK_LAST) ? '0 : r_presc + 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop_btn) begin
                    w_timer_clearn = 1'b0;
                    w_digit_cnt    = 2'd0;
                    w_state        = S_IDLE;
                end else if (start_btn && door_closed) begin
                    w_state = S_COOK;
                end
            end
            S_DONE: begin
                if (!door_closed || stop_btn || start_btn || key_valid ||
                    (r_alarm_cnt == c_ALARM_LAST)) begin
                    w_digit_cnt = 2'd0;
                    w_state     = S_IDLE;
                end else begin
                    w_alarm_cnt = r_alarm_cnt + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clearn) begin
            r_state        <= S_IDLE;
            r_digit_cnt    <= 2'd0;
            r_presc        <= '0;
            r_alarm_cnt    <= '0;
            r_timer_data   <= 4'd0;
            r_timer_loadn  <= 1'b1;
            r_timer_clearn <= 1'b0;
            r_timer_enable <= 1'b0;
            r_mag_on       <= 1'b0;
            r_alarm        <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_digit_cnt    <= w_digit_cnt;
            r_presc        <= w_presc;
            r_alarm_cnt    <= w_alarm_cnt;
            r_timer_data   <= w_timer_data;
            r_timer_loadn  <= w_timer_loadn;
            r_timer_clearn <= w_timer_clearn;
            r_timer_enable <= w_timer_enable;
            r_mag_on       <= (w_state == S_COOK);
            r_alarm        <= (w_state == S_DONE);
            r_busy         <= (w_state == S_COOK) || (w_state == S_PAUSE);
        end
    end

    assign timer_data   = r_timer_data;
    assign timer_loadn  = r_timer_loadn;
    assign timer_clearn = r_timer_clearn;
    assign timer_enable = r_timer_enable;
    assign mag_on       = r_mag_on;
    assign alarm        = r_alarm;
    assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_cook_controller.sv
// ============================================================================
//  Module      : tb_cook_controller
//  Description : Directed self-checking bench for cook_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cook_controller;

    logic       clock = 1'b0;
    logic       clearn = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       start_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       door_closed = 1'b1;
    logic       timer_zero;
    logic [3:0] timer_data;
    logic       timer_loadn, timer_clearn, timer_enable, mag_on, alarm, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int tsec     = 0;

    cook_controller #(.TICK_DIV(4), .ALARM_CYCLES(5)) dut (
        .clock        (clock),
        .clearn       (clearn),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .start_btn    (start_btn),
        .stop_btn     (stop_btn),
        .door_closed  (door_closed),
        .timer_zero   (timer_zero),
        .timer_data   (timer_data),
        .timer_loadn  (timer_loadn),
        .timer_clearn (timer_clearn),
        .timer_enable (timer_enable),
        .mag_on       (mag_on),
        .alarm        (alarm),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Simple external timer: decimal seconds, shift-in on load, decrement on enable.
    always @(posedge clock) begin
        if (!timer_clearn)                 tsec <= 0;
        else if (!timer_loadn)             tsec <= (tsec * 10 + int'(timer_data)) % 1000;
        else if (timer_enable && tsec > 0) tsec <= tsec - 1;
    end
    assign timer_zero = (tsec == 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press_key(input int k, input bit accept);
        key_code  = 4'(k);
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check("key_loadn", 32'(timer_loadn), accept ? 32'd0 : 32'd1);
        if (accept) check("key_data", 32'(timer_data), 32'(k));
        tick();
        check("loadn_release", 32'(timer_loadn), 32'd1);
    endtask

    task automatic pulse_start();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_clearn", 32'(timer_clearn), 32'd0);
        check("rst_loadn",  32'(timer_loadn),  32'd1);
        check("rst_enable", 32'(timer_enable), 32'd0);
        check("rst_mag",    32'(mag_on),       32'd0);
        check("rst_alarm",  32'(alarm),        32'd0);
        check("rst_busy",   32'(busy),         32'd0);
        check("rst_data",   32'(timer_data),   32'd0);
        clearn = 1'b1;
        tick();
        check("clearn_release", 32'(timer_clearn), 32'd1);

        // Digit entry 1,3,0 then a rejected fourth digit
        press_key(1, 1'b1);
        press_key(3, 1'b1);
        press_key(0, 1'b1);
        check("state_entry", 32'(dut.r_state), 32'd1);
        check("tsec_130", 32'(tsec), 32'd130);
        press_key(5, 1'b0);
        pulse_stop();
        check("stop_entry_clearn", 32'(timer_clearn), 32'd0);
        check("stop_entry_idle", 32'(dut.r_state), 32'd0);
        tick();
        check("stop_entry_release", 32'(timer_clearn), 32'd1);

        // Invalid code ignored; start with timer at zero ignored
        press_key(12, 1'b0);
        press_key(0, 1'b1);
        pulse_start();
        check("zero_start_mag", 32'(mag_on), 32'd0);
        check("zero_start_state", 32'(dut.r_state), 32'd1);
        pulse_stop();
        tick();

        // Cook 0:02 with TICK_DIV=4, ALARM_CYCLES=5
        press_key(0, 1'b1);
        press_key(2, 1'b1);
        pulse_start();
        check("cook_mag", 32'(mag_on), 32'd1);
        check("cook_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check($sformatf("cook_en_%0d", k), 32'(timer_enable), (k == 4 || k == 8) ? 32'd1 : 32'd0);
            if (k == 9)  check("mag_before_done", 32'(mag_on), 32'd1);
            if (k == 10) begin
                check("done_alarm", 32'(alarm), 32'd1);
                check("done_mag",   32'(mag_on), 32'd0);
                check("done_busy",  32'(busy),   32'd0);
            end
            if (k == 14) check("alarm_last", 32'(alarm), 32'd1);
            if (k == 15) begin
                check("alarm_off", 32'(alarm), 32'd0);
                check("idle_after_alarm", 32'(dut.r_state), 32'd0);
            end
        end

        // Door opens mid-cook; resume keeps the prescaler count
        press_key(5, 1'b1);
        pulse_start();
        tick();
        tick();
        door_closed = 1'b0;
        tick();
        check("door_pause_mag", 32'(mag_on), 32'd0);
        check("door_pause_busy", 32'(busy), 32'd1);
        pulse_start();
        check("start_door_open", 32'(mag_on), 32'd0);
        door_closed = 1'b1;
        tick();
        pulse_start();
        check("resume_mag", 32'(mag_on), 32'd1);
        tick();
        check("resume_en_1", 32'(timer_enable), 32'd0);
        tick();
        check("resume_en_2", 32'(timer_enable), 32'd1);

        // Stop pauses, second stop cancels
        pulse_stop();
        check("stop_pause_mag", 32'(mag_on), 32'd0);
        check("stop_pause_busy", 32'(busy), 32'd1);
        pulse_stop();
        check("cancel_clearn", 32'(timer_clearn), 32'd0);
        check("cancel_busy", 32'(busy), 32'd0);
        check("cancel_digits", 32'(dut.r_digit_cnt), 32'd0);
        tick();
        check("cancel_release", 32'(timer_clearn), 32'd1);

        // Start and stop together while cooking
        press_key(7, 1'b1);
        pulse_start();
        tick();
        start_btn = 1'b1;
        stop_btn  = 1'b1;
        tick();
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        check("both_pause_busy", 32'(busy), 32'd1);
        check("both_pause_mag", 32'(mag_on), 32'd0);
        pulse_stop();
        tick();

        // Reset mid-cook
        press_key(9, 1'b1);
        pulse_start();
        tick();
        clearn = 1'b0;
        tick();
        check("midrst_mag",    32'(mag_on),       32'd0);
        check("midrst_clearn", 32'(timer_clearn), 32'd0);
        check("midrst_busy",   32'(busy),         32'd0);
        check("midrst_loadn",  32'(timer_loadn),  32'd1);
        check("midrst_enable", 32'(timer_enable), 32'd0);
        check("midrst_data",   32'(timer_data),   32'd0);
        check("midrst_alarm",  32'(alarm),        32'd0);
        check("midrst_state",  32'(dut.r_state),  32'd0);
        clearn = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
